// File: rtl/alu_axi_lite_seq_master_if.sv
// AXI-Lite link between the ALU sequencer (master) and the ALU register slave.
interface alu_axi_lite_seq_master_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   m_axi_awaddr;
  logic [2:0]          m_axi_awprot;
  logic                m_axi_awvalid;
  logic                m_axi_awready;
  logic [DATA_W-1:0]   m_axi_wdata;
  logic [DATA_W/8-1:0] m_axi_wstrb;
  logic                m_axi_wvalid;
  logic                m_axi_wready;
  logic [1:0]          m_axi_bresp;
  logic                m_axi_bvalid;
  logic                m_axi_bready;
  logic [ADDR_W-1:0]   m_axi_araddr;
  logic [2:0]          m_axi_arprot;
  logic                m_axi_arvalid;
  logic                m_axi_arready;
  logic [DATA_W-1:0]   m_axi_rdata;
  logic [1:0]          m_axi_rresp;
  logic                m_axi_rvalid;
  logic                m_axi_rready;

  modport master (
    output m_axi_awaddr, m_axi_awprot, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
           m_axi_bready, m_axi_araddr, m_axi_arprot, m_axi_arvalid, m_axi_rready,
    input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
           m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
  );

  modport slave (
    input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
           m_axi_bready, m_axi_araddr, m_axi_arprot, m_axi_arvalid, m_axi_rready,
    output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
           m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
  );
endinterface

// File: rtl/alu_axi_lite_seq_master.sv
// Sequences one command into A/B/control writes plus a result read on the ALU slave,
// returning the 16-bit result with a sticky error flag on a valid/ready port.
module alu_axi_lite_seq_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_opcode,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_err,
  output logic        busy,
  output logic [15:0] op_count,
  alu_axi_lite_seq_master_if.master m_axi
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, WR, WRESP, RADDR, RDATA, DONE} state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;

  // every bus-facing output lives in this register bundle
  typedef struct packed {
    logic          awvalid;
    logic          wvalid;
    logic          bready;
    logic          arvalid;
    logic          rready;
    logic          rsp_valid;
    logic          err;
    logic [AW-1:0] awaddr;
    logic [AW-1:0] araddr;
    logic [DW-1:0] wdata;
    logic [15:0]   result;
  } out_t;

  state_t      st_q, st_d;
  logic [1:0]  idx_q, idx_d;
  cmd_t        cmd_q, cmd_d;
  out_t        o_q, o_d;
  logic [15:0] cnt_q, cnt_d;

  function automatic logic [AW-1:0] beat_addr(input logic [1:0] i);
    return C_BASE_ADDR + AW'({i, 2'b00});
  endfunction

  function automatic logic [DW-1:0] beat_data(input logic [1:0] i, input cmd_t c);
    logic [DW-1:0] d;
    unique case (i)
      2'd0:    d = DW'(c.a);
      2'd1:    d = DW'(c.b);
      default: d = DW'({1'b1, c.op});
    endcase
    return d;
  endfunction

  always_comb begin
    st_d  = st_q;
    idx_d = idx_q;
    cmd_d = cmd_q;
    o_d   = o_q;
    cnt_d = cnt_q;
    unique case (st_q)
      IDLE: if (cmd_valid) begin
        cmd_d      = '{a: cmd_a, b: cmd_b, op: cmd_opcode};
        idx_d      = 2'd0;
        o_d.err    = 1'b0;
        o_d.awvalid = 1'b1;
        o_d.wvalid  = 1'b1;
        o_d.awaddr  = beat_addr(2'd0);
        o_d.wdata   = beat_data(2'd0, cmd_d);
        st_d        = WR;
      end
      WR: begin
        // AW and W retire independently; move on once both are gone
        if (m_axi.m_axi_awready) o_d.awvalid = 1'b0;
        if (m_axi.m_axi_wready)  o_d.wvalid  = 1'b0;
        if (!o_d.awvalid && !o_d.wvalid) begin
          o_d.bready = 1'b1;
          st_d       = WRESP;
        end
      end
      WRESP: if (m_axi.m_axi_bvalid) begin
        o_d.err    = o_q.err | (m_axi.m_axi_bresp != 2'b00);
        o_d.bready = 1'b0;
        if (idx_q != 2'd2) begin
          idx_d       = idx_q + 2'd1;
          o_d.awvalid = 1'b1;
          o_d.wvalid  = 1'b1;
          o_d.awaddr  = beat_addr(idx_d);
          o_d.wdata   = beat_data(idx_d, cmd_q);
          st_d        = WR;
        end else begin
          o_d.arvalid = 1'b1;
          o_d.araddr  = C_BASE_ADDR + AW'(4'hC);
          st_d        = RADDR;
        end
      end
      RADDR: if (m_axi.m_axi_arready) begin
        o_d.arvalid = 1'b0;
        o_d.rready  = 1'b1;
        st_d        = RDATA;
      end
      RDATA: if (m_axi.m_axi_rvalid) begin
        o_d.rready    = 1'b0;
        o_d.result    = m_axi.m_axi_rdata[15:0];
        o_d.err       = o_q.err | (m_axi.m_axi_rresp != 2'b00);
        o_d.rsp_valid = 1'b1;
        st_d          = DONE;
      end
      DONE: if (rsp_ready) begin
        o_d.rsp_valid = 1'b0;
        cnt_d         = cnt_q + 16'd1;
        st_d          = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      st_q  <= IDLE;
      idx_q <= '0;
      cmd_q <= '0;
      o_q   <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      idx_q <= idx_d;
      cmd_q <= cmd_d;
      o_q   <= o_d;
      cnt_q <= cnt_d;
    end
  end

  logic unused_rdata;
  assign unused_rdata = ^m_axi.m_axi_rdata[DW-1:16];

  assign cmd_ready  = (st_q == IDLE) && s_axi_aresetn;
  assign busy       = (st_q != IDLE);
  assign rsp_valid  = o_q.rsp_valid;
  assign rsp_result = o_q.result;
  assign rsp_err    = o_q.err;
  assign op_count   = cnt_q;

  assign m_axi.m_axi_awaddr  = o_q.awaddr;
  assign m_axi.m_axi_awprot  = 3'b000;
  assign m_axi.m_axi_awvalid = o_q.awvalid;
  assign m_axi.m_axi_wdata   = o_q.wdata;
  assign m_axi.m_axi_wstrb   = '1;
  assign m_axi.m_axi_wvalid  = o_q.wvalid;
  assign m_axi.m_axi_bready  = o_q.bready;
  assign m_axi.m_axi_araddr  = o_q.araddr;
  assign m_axi.m_axi_arprot  = 3'b000;
  assign m_axi.m_axi_arvalid = o_q.arvalid;
  assign m_axi.m_axi_rready  = o_q.rready;
endmodule

// File: tb/tb_alu_axi_lite_seq_master.sv
// Directed bench: ALU-register slave model with tunable ready delays and error injection.
module tb_alu_axi_lite_seq_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
  logic [7:0]  cmd_a = '0, cmd_b = '0;
  logic [2:0]  cmd_opcode = '0;
  logic [15:0] rsp_result, op_count;

  alu_axi_lite_seq_master_if #(.ADDR_W(4), .DATA_W(32)) bus();

  alu_axi_lite_seq_master #(
    .C_M_AXI_ADDR_WIDTH(4), .C_M_AXI_DATA_WIDTH(32), .C_BASE_ADDR(4'h0)
  ) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_opcode(cmd_opcode), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy), .op_count(op_count),
    .m_axi(bus)
  );

  int total = 0;
  int bad = 0;

  // ---------------- slave model ----------------
  int aw_dly = 0, w_dly = 0, ar_dly = 0;
  logic [3:0] err_addr = 4'hF;
  int n_wr = 0, n_rd = 0;
  logic [3:0]  log_wa[$];
  logic [31:0] log_wd[$];
  logic [3:0]  log_ra[$];
  int aw_cnt, w_cnt, ar_cnt;
  logic aw_got, w_got;
  logic [3:0] aw_lat;
  logic [31:0] w_lat;
  logic [7:0] ra, rb;
  logic [3:0] rc;

  function automatic logic [15:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
    if (!c[3]) return 16'h0;
    case (c[2:0])
      3'd0: return 16'(a) + 16'(b);
      3'd1: return 16'(a) - 16'(b);
      3'd2: return 16'(a & b);
      3'd3: return 16'(a | b);
      3'd4: return 16'(a ^ b);
      3'd5: return 16'(a) * 16'(b);
      default: return 16'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin : bfm
    logic aw_hs, w_hs;
    logic [3:0] wa;
    logic [31:0] wd;
    if (!rst_n) begin
      bus.m_axi_awready <= 1'b0; bus.m_axi_wready <= 1'b0;
      bus.m_axi_bvalid <= 1'b0;  bus.m_axi_bresp <= 2'b00;
      bus.m_axi_arready <= 1'b0; bus.m_axi_rvalid <= 1'b0;
      bus.m_axi_rresp <= 2'b00;  bus.m_axi_rdata <= '0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
    end else begin
      aw_hs = bus.m_axi_awvalid && bus.m_axi_awready;
      w_hs  = bus.m_axi_wvalid && bus.m_axi_wready;
      if (aw_hs) begin
        bus.m_axi_awready <= 1'b0; aw_got <= 1'b1; aw_lat <= bus.m_axi_awaddr;
      end else if (bus.m_axi_awvalid && !aw_got && !bus.m_axi_awready) begin
        if (aw_cnt >= aw_dly) begin bus.m_axi_awready <= 1'b1; aw_cnt <= 0; end
        else aw_cnt <= aw_cnt + 1;
      end
      if (w_hs) begin
        bus.m_axi_wready <= 1'b0; w_got <= 1'b1; w_lat <= bus.m_axi_wdata;
      end else if (bus.m_axi_wvalid && !w_got && !bus.m_axi_wready) begin
        if (w_cnt >= w_dly) begin bus.m_axi_wready <= 1'b1; w_cnt <= 0; end
        else w_cnt <= w_cnt + 1;
      end
      if ((aw_got || aw_hs) && (w_got || w_hs) && !bus.m_axi_bvalid) begin
        wa = aw_hs ? bus.m_axi_awaddr : aw_lat;
        wd = w_hs ? bus.m_axi_wdata : w_lat;
        case (wa)
          4'h0: ra <= wd[7:0];
          4'h4: rb <= wd[7:0];
          4'h8: rc <= wd[3:0];
          default: ;
        endcase
        log_wa.push_back(wa);
        log_wd.push_back(wd);
        n_wr <= n_wr + 1;
        bus.m_axi_bvalid <= 1'b1;
        bus.m_axi_bresp  <= (wa == err_addr) ? 2'b10 : 2'b00;
        aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (bus.m_axi_bvalid && bus.m_axi_bready) bus.m_axi_bvalid <= 1'b0;
      if (bus.m_axi_arvalid && bus.m_axi_arready) begin
        bus.m_axi_arready <= 1'b0;
        log_ra.push_back(bus.m_axi_araddr);
        n_rd <= n_rd + 1;
        bus.m_axi_rvalid <= 1'b1;
        bus.m_axi_rdata  <= {16'h0, alu(ra, rb, rc)};
        bus.m_axi_rresp  <= 2'b00;
      end else if (bus.m_axi_arvalid && !bus.m_axi_arready && !bus.m_axi_rvalid) begin
        if (ar_cnt >= ar_dly) begin bus.m_axi_arready <= 1'b1; ar_cnt <= 0; end
        else ar_cnt <= ar_cnt + 1;
      end
      if (bus.m_axi_rvalid && bus.m_axi_rready) bus.m_axi_rvalid <= 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // called at a negedge with the DUT idle; returns at the negedge of accept cycle + 1
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    chk("cmd_ready_before_send", cmd_ready, 1);
    cmd_a = a; cmd_b = b; cmd_opcode = op; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // wait for rsp_valid while checking valids stay up with stable payload until handshake
  task automatic wait_rsp(input string tag);
    int n = 0;
    logic pav = 0, par = 0, pwv = 0, pwr = 0, prv = 0, prr = 0;
    logic [3:0] pa = 0, pra = 0;
    logic [31:0] pwd = 0;
    while (!rsp_valid && n < 200) begin
      if (pav) begin
        chk({tag, "_awvalid_hold"}, bus.m_axi_awvalid, !par);
        if (!par) chk({tag, "_awaddr_stable"}, bus.m_axi_awaddr, pa);
      end
      if (pwv) begin
        chk({tag, "_wvalid_hold"}, bus.m_axi_wvalid, !pwr);
        if (!pwr) chk({tag, "_wdata_stable"}, bus.m_axi_wdata, pwd);
      end
      if (prv) begin
        chk({tag, "_arvalid_hold"}, bus.m_axi_arvalid, !prr);
        if (!prr) chk({tag, "_araddr_stable"}, bus.m_axi_araddr, pra);
      end
      pav = bus.m_axi_awvalid; par = bus.m_axi_awready; pa = bus.m_axi_awaddr;
      pwv = bus.m_axi_wvalid;  pwr = bus.m_axi_wready;  pwd = bus.m_axi_wdata;
      prv = bus.m_axi_arvalid; prr = bus.m_axi_arready; pra = bus.m_axi_araddr;
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk({tag, "_rsp_timeout"}, rsp_valid, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int wb, rb0, k;
    logic hit;

    // reset state
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valids", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid,
                       bus.m_axi_bready, bus.m_axi_rready}, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_result}, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_tieoffs", {bus.m_axi_awprot, bus.m_axi_arprot, bus.m_axi_wstrb}, 32'h00F);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: ADD 0x12+0x34, ALU-like slave, rsp_ready high; response at cycle 13
    rsp_ready = 1'b1;
    wb = log_wa.size(); rb0 = log_ra.size();
    send(8'h12, 8'h34, 3'd0);
    chk("add_busy", busy, 1);
    repeat (11) @(negedge clk);
    chk("add_rsp_not_c12", rsp_valid, 0);
    @(negedge clk);
    chk("add_rsp_at_c13", rsp_valid, 1);
    chk("add_result", rsp_result, 16'h0046);
    chk("add_err", rsp_err, 0);
    chk("add_wa0", log_wa[wb],   4'h0); chk("add_wd0", log_wd[wb],   32'h12);
    chk("add_wa1", log_wa[wb+1], 4'h4); chk("add_wd1", log_wd[wb+1], 32'h34);
    chk("add_wa2", log_wa[wb+2], 4'h8); chk("add_wd2", log_wd[wb+2], 32'h8);
    chk("add_ra",  log_ra[rb0],  4'hC);
    @(negedge clk);
    chk("add_op_count", op_count, 1);
    chk("add_b2b_cmd_ready", cmd_ready, 1);

    // 2: skewed handshakes, MUL 0x10*0x11
    aw_dly = 0; w_dly = 2; ar_dly = 5;
    wb = n_wr; rb0 = n_rd;
    send(8'h10, 8'h11, 3'd5);
    wait_rsp("skew");
    chk("skew_result", rsp_result, 16'h0110);
    chk("skew_err", rsp_err, 0);
    chk("skew_nwr", n_wr - wb, 3);
    chk("skew_nrd", n_rd - rb0, 1);
    chk("skew_wd2", log_wd[wb+2], 32'hD);
    chk("skew_ra", log_ra[rb0], 4'hC);
    @(negedge clk);
    chk("skew_op_count", op_count, 2);
    aw_dly = 0; w_dly = 0; ar_dly = 0;

    // 3: error on the B write, then a clean command
    err_addr = 4'h4;
    wb = n_wr; rb0 = n_rd;
    send(8'h03, 8'h05, 3'd1);
    wait_rsp("err");
    chk("err_flag", rsp_err, 1);
    chk("err_result", rsp_result, 16'hFFFE);
    chk("err_nwr", n_wr - wb, 3);
    chk("err_nrd", n_rd - rb0, 1);
    @(negedge clk);
    err_addr = 4'hF;
    send(8'h0F, 8'hF0, 3'd3);
    wait_rsp("clean");
    chk("clean_err", rsp_err, 0);
    chk("clean_result", rsp_result, 16'h00FF);
    @(negedge clk);
    chk("clean_op_count", op_count, 4);

    // 4: response backpressure, competing command must be ignored
    rsp_ready = 1'b0;
    send(8'hA5, 8'h0F, 3'd4);
    wait_rsp("bp");
    chk("bp_result", rsp_result, 16'h00AA);
    wb = n_wr;
    cmd_a = 8'h01; cmd_b = 8'h01; cmd_opcode = 3'd0; cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_result", rsp_result, 16'h00AA);
      chk("bp_rsp_err", rsp_err, 0);
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", rsp_valid, 0);
    chk("bp_release_count", op_count, 5);
    @(negedge clk);
    chk("bp_single_handshake", op_count, 5);
    chk("bp_no_new_cmd", busy, 0);
    chk("bp_no_extra_writes", n_wr - wb, 0);

    // 5: reset while waiting for the control-write response
    send(8'h01, 8'h02, 3'd0);
    hit = 1'b0;
    k = 0;
    while (!hit && k < 50) begin
      if (bus.m_axi_bready && bus.m_axi_awaddr == 4'h8) hit = 1'b1;
      else begin @(negedge clk); k++; end
    end
    chk("rst_mid_found_wresp", {bus.m_axi_bready, bus.m_axi_awaddr}, 5'h18);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valids", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid,
                           bus.m_axi_bready, bus.m_axi_rready, rsp_valid}, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_op_count", op_count, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h20, 8'h22, 3'd0);
    wait_rsp("post_rst");
    chk("post_rst_result", rsp_result, 16'h0042);
    chk("post_rst_err", rsp_err, 0);
    @(negedge clk);
    chk("post_rst_op_count", op_count, 1);

    // 6: op_count wrap
    force dut.cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.cnt_q;
    chk("wrap_preload", op_count, 16'hFFFF);
    send(8'h02, 8'h02, 3'd0);
    wait_rsp("wrap");
    chk("wrap_result", rsp_result, 16'h0004);
    @(negedge clk);
    chk("wrap_op_count", op_count, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
